// File: rtl/f2c_dma_sched.sv
// F2C ring DMA sequencer: buffers a 64-bit source stream and writes it one slot per TLP into the
// host ring, each data TLP followed by a 1-qword write-pointer update. Optional stall counter: F2C_DMA_SCHED_STATS_EN.
module f2c_dma_sched #(
    parameter int SLOT_QWORDS = 16,
    parameter int NUM_SLOTS   = 16,
    parameter int FIFO_DEPTH  = 32,
    localparam int PTR_W      = $clog2(NUM_SLOTS)
) (
    input  logic             clk_in,
    input  logic             rstn,
`ifdef F2C_DMA_SCHED_STATS_EN
    output logic [31:0]      stallCount_out,
`endif
    input  logic [31:0]      cfgF2CBase_in,
    input  logic [31:0]      cfgMtrBase_in,
    input  logic             dmaEnable_in,
    input  logic             rdPtrWrite_in,
    input  logic [PTR_W-1:0] rdPtrData_in,
    input  logic [63:0]      srcData_in,
    input  logic             srcValid_in,
    output logic             srcReady_out,
    output logic [31:0]      txAddr_out,
    output logic [5:0]       txLen_out,
    output logic [63:0]      txData_out,
    output logic             txSop_out,
    output logic             txEop_out,
    output logic             txValid_out,
    input  logic             txReady_in,
    output logic [PTR_W-1:0] wrPtr_out,
    output logic             full_out,
    output logic             busy_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(SLOT_QWORDS);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_MTR} state_t;

    state_t           r_state, w_next;
    logic [63:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_idx, r_rd_idx;
    logic [CW-1:0]    r_count;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [QW-1:0]    r_qcnt;
    logic [31:0]      r_tx_addr;
    logic [5:0]       r_tx_len;

    // Both sides use valid/ready: a qword moves on the rising edge where valid && ready; the
    // sender keeps every payload/control output unchanged while valid is high and ready is low.
    logic w_push, w_xfer, w_pop, w_last, w_flush, w_start;

    assign srcReady_out = dmaEnable_in && (r_count != CW'(FIFO_DEPTH));
    assign w_push   = srcValid_in && srcReady_out;
    assign w_xfer   = txValid_out && txReady_in;
    assign w_pop    = (r_state == S_DATA) && w_xfer;
    assign w_last   = w_pop && (r_qcnt == QW'(SLOT_QWORDS - 1));
    assign w_flush  = (r_state == S_IDLE) && !dmaEnable_in;
    assign full_out = (r_wr_ptr + PTR_W'(1)) == r_rd_ptr;
    assign w_start  = (r_state == S_IDLE) && dmaEnable_in && !full_out
                      && (r_count >= CW'(SLOT_QWORDS));

    assign wrPtr_out  = r_wr_ptr;
    assign txAddr_out = r_tx_addr;
    assign txLen_out  = r_tx_len;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        txValid_out = 1'b0;
        txSop_out   = 1'b0;
        txEop_out   = 1'b0;
        txData_out  = 64'd0;
        busy_out    = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_DATA;
            S_DATA: begin
                txValid_out = 1'b1;
                busy_out    = 1'b1;
                txSop_out   = (r_qcnt == '0);
                txEop_out   = (r_qcnt == QW'(SLOT_QWORDS - 1));
                txData_out  = r_mem[r_rd_idx];
                if (w_last) w_next = S_MTR;
            end
            S_MTR: begin
                txValid_out = 1'b1;
                busy_out    = 1'b1;
                txSop_out   = 1'b1;
                txEop_out   = 1'b1;
                txData_out  = {{(64-PTR_W){1'b0}}, r_wr_ptr};
                if (w_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_idx] <= srcData_in;
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            r_wr_idx <= r_wr_idx + AW'(w_push);
            r_rd_idx <= r_rd_idx + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Disable in IDLE rewinds both pointers and wins over a concurrent host read-pointer strobe.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_last)        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (rdPtrWrite_in) r_rd_ptr <= rdPtrData_in;
        end
    end

    // Address/length are captured once per TLP so config changes never disturb a TLP in flight.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_tx_addr <= '0;
            r_tx_len  <= '0;
            r_qcnt    <= '0;
        end else if (w_start) begin
            r_tx_addr <= cfgF2CBase_in + (32'(r_wr_ptr) * 32'(SLOT_QWORDS));
            r_tx_len  <= 6'(SLOT_QWORDS);
            r_qcnt    <= '0;
        end else if (w_last) begin
            r_tx_addr <= cfgMtrBase_in;
            r_tx_len  <= 6'd1;
            r_qcnt    <= '0;
        end else if (w_pop) begin
            r_qcnt    <= r_qcnt + QW'(1);
        end
    end

`ifdef F2C_DMA_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;
    assign stallCount_out = r_stall_cnt;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn)
            r_stall_cnt <= '0;
        else if (!dmaEnable_in)
            r_stall_cnt <= '0;
        else if ((r_state == S_IDLE) && full_out && (r_count >= CW'(SLOT_QWORDS))
                 && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_f2c_dma_sched.sv
// Scoreboard bench for f2c_dma_sched: expected TLP beats are queued as source data is generated
// and compared beat-by-beat at the transceiver port.
module tb_f2c_dma_sched;
    localparam int SLOT  = 16;
    localparam int NSLOT = 16;
    localparam int BW    = 104;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] f2c_base = '0;
    logic [31:0] mtr_base = '0;
    logic        dma_en = 1'b0;
    logic        rd_ptr_write = 1'b0;
    logic [3:0]  rd_ptr_data = '0;
    logic [63:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [31:0] tx_addr;
    logic [5:0]  tx_len;
    logic [63:0] tx_data;
    logic        tx_sop, tx_eop, tx_valid;
    logic        tx_ready = 1'b0;
    logic [3:0]  wr_ptr;
    logic        full, busy;
`ifdef F2C_DMA_SCHED_STATS_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_beats  = 0;
    bit bp_mode  = 1'b0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] pend_q[$];
    logic [63:0]   src_q[$];

    f2c_dma_sched dut (
        .clk_in(clk), .rstn(rst_n),
`ifdef F2C_DMA_SCHED_STATS_EN
        .stallCount_out(stall_count),
`endif
        .cfgF2CBase_in(f2c_base), .cfgMtrBase_in(mtr_base), .dmaEnable_in(dma_en),
        .rdPtrWrite_in(rd_ptr_write), .rdPtrData_in(rd_ptr_data),
        .srcData_in(src_data), .srcValid_in(src_valid), .srcReady_out(src_ready),
        .txAddr_out(tx_addr), .txLen_out(tx_len), .txData_out(tx_data),
        .txSop_out(tx_sop), .txEop_out(tx_eop), .txValid_out(tx_valid), .txReady_in(tx_ready),
        .wrPtr_out(wr_ptr), .full_out(full), .busy_out(busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input logic [31:0] a, input logic [5:0] l,
                                           input logic [63:0] d, input logic s, input logic e);
        return {a, l, d, s, e};
    endfunction

    // ready driver: steady 1, or toggling every cycle in backpressure mode
    always begin
        @(posedge clk);
        #1;
        tx_ready = bp_mode ? ~tx_ready : 1'b1;
    end

    // monitor: compares each accepted beat and checks that stalled beats are held
    logic [BW-1:0] mon_saved;
    bit            mon_stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_stalled)
                check("stall_hold", {tx_addr, tx_len, tx_data, tx_sop, tx_eop}, mon_saved);
            if (tx_valid && tx_ready) begin
                n_beats++;
                if (exp_q.size() == 0)
                    check("unexpected_beat", {tx_addr, tx_len, tx_data, tx_sop, tx_eop}, '0);
                else
                    check("beat", {tx_addr, tx_len, tx_data, tx_sop, tx_eop}, exp_q.pop_front());
            end
            mon_stalled = tx_valid && !tx_ready;
            mon_saved   = {tx_addr, tx_len, tx_data, tx_sop, tx_eop};
        end
    end

    // driver tasks
    task automatic queue_slot(input int slot, input bit expect_now);
        logic [63:0]   d;
        logic [BW-1:0] b;
        for (int i = 0; i < SLOT; i++) begin
            d = {$urandom, $urandom};
            src_q.push_back(d);
            b = beat(f2c_base + 32'(slot * SLOT), 6'(SLOT), d, i == 0, i == SLOT - 1);
            if (expect_now) exp_q.push_back(b); else pend_q.push_back(b);
        end
        b = beat(mtr_base, 6'd1, 64'((slot + 1) % NSLOT), 1'b1, 1'b1);
        if (expect_now) exp_q.push_back(b); else pend_q.push_back(b);
    endtask

    task automatic push_src(input logic [63:0] d);
        int waited = 0;
        src_valid = 1'b1;
        src_data  = d;
        @(negedge clk);
        while (!src_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!src_ready) check("src_timeout", 0, 1);
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic send_all();
        while (src_q.size() != 0) push_src(src_q.pop_front());
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic disable_ring();
        dma_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("dis_wrptr", wr_ptr, 0);
        check("dis_srcready", src_ready, 0);
        check("dis_full", full, 0);
`ifdef F2C_DMA_SCHED_STATS_EN
        check("stats_clear", stall_count, 0);
`endif
        @(posedge clk);
        #1;
        dma_en = 1'b1;
    endtask

    initial begin
        int b0, c;
        logic [31:0] s0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", tx_valid, 0);
        check("rst_srcready", src_ready, 0);
        check("rst_wrptr", wr_ptr, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_payload", {tx_addr, tx_len, tx_data, tx_sop, tx_eop}, '0);
        @(posedge clk);
        #1;

        // basic slot write
        f2c_base = 32'h0;
        mtr_base = 32'h100;
        dma_en   = 1'b1;
        queue_slot(0, 1'b1);
        send_all();
        wait_drain("basic_drain");
        check("basic_wrptr", wr_ptr, 1);
        check("basic_busy", busy, 0);

        // full ring: 15 slots go out, the 16th is withheld until the host frees a slot
        disable_ring();
        for (int s = 0; s < NSLOT - 1; s++) queue_slot(s, 1'b1);
        queue_slot(NSLOT - 1, 1'b0);
        send_all();
        wait_drain("ring_drain");
        repeat (20) @(posedge clk);
        #1;
        check("ring_full", full, 1);
        check("ring_wrptr", wr_ptr, 15);
        check("ring_withheld", busy, 0);
`ifdef F2C_DMA_SCHED_STATS_EN
        s0 = stall_count;
        repeat (100) @(posedge clk);
        #1;
        check("stats_100", stall_count - s0, 100);
`else
        s0 = '0;
`endif
        while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        rd_ptr_write = 1'b1;
        rd_ptr_data  = 4'd1;
        @(posedge clk);
        #1;
        rd_ptr_write = 1'b0;
        wait_drain("ring_release_drain");
        check("ring_wrap_wrptr", wr_ptr, 0);
        check("ring_wrap_full", full, 1);

        // backpressure with a base that wraps the 32-bit address space later
        disable_ring();
        f2c_base = 32'hFFFF_FF80;
        mtr_base = 32'h0000_0200;
        bp_mode  = 1'b1;
        queue_slot(0, 1'b1);
        send_all();
        wait_drain("bp_drain");
        bp_mode = 1'b0;
        check("bp_wrptr", wr_ptr, 1);

        // disable mid-TLP: the TLP and metrics write complete, leftover qwords are flushed
        disable_ring();
        b0 = n_beats;
        queue_slot(0, 1'b1);
        for (int i = 0; i < 4; i++) src_q.push_back({$urandom, $urandom});
        send_all();
        c = 0;
        while (n_beats < b0 + 6 && c < 500) begin
            @(posedge clk);
            c++;
        end
        check("mid_reach_q5", n_beats >= b0 + 6, 1);
        #1;
        dma_en = 1'b0;
        wait_drain("mid_drain");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_wrptr", wr_ptr, 0);
        check("mid_srcready", src_ready, 0);
        check("mid_busy", busy, 0);
        @(posedge clk);
        #1;
        dma_en = 1'b1;

        // wrPtr increment coincident with an rdPtr strobe (addresses wrap past 2^32)
        for (int s = 0; s < 14; s++) queue_slot(s, 1'b1);
        send_all();
        wait_drain("sim_setup_drain");
        check("sim_setup_wrptr", wr_ptr, 14);
        queue_slot(14, 1'b1);
        send_all();
        c = 0;
        @(negedge clk);
        while (!(tx_valid && tx_eop && tx_len == 6'(SLOT)) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("sim_found_eop", tx_valid && tx_eop, 1);
        rd_ptr_write = 1'b1;
        rd_ptr_data  = 4'd3;
        @(posedge clk);
        #1;
        rd_ptr_write = 1'b0;
        @(negedge clk);
        check("sim_wrptr", wr_ptr, 15);
        check("sim_full", full, 0);
        wait_drain("sim_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/f2c_dma_sched.md
Name: f2c_dma_sched

Overview:
- Sequences FPGA->host DMA into the F2C ring in host memory: 16 slots of 128 bytes (16 qwords).
- Buffers a 64-bit source stream and emits one 16-qword memory-write TLP request per slot to the TLP transceiver.
- After each data TLP, emits a 1-qword write of the new write pointer into the metrics buffer.
- Sits between the register block (F2C_BASE, MTR_BASE, DMA_ENABLE, F2C_RDPTR) and tlp_xcvr's upstream request port.

Parameters:
- SLOT_QWORDS, 16, qwords per ring slot and per data TLP; power of 2, 2..32.
- NUM_SLOTS, 16, ring slots; power of 2, 2..256. PTR_W = log2(NUM_SLOTS).
- FIFO_DEPTH, 32, source buffer depth in qwords; power of 2, >= SLOT_QWORDS.

Ports:
- clk_in  in  1  PCIe application clock.
- rstn  in  1  async active-low reset.
- cfgF2CBase_in  in  32  ring base, qword address (byte addr / 8).
- cfgMtrBase_in  in  32  metrics base, qword address.
- dmaEnable_in  in  1  DMA enable level.
- rdPtrWrite_in  in  1  strobe: host wrote F2C_RDPTR.
- rdPtrData_in  in  PTR_W  new host read pointer.
- srcData_in  in  64  source qword.
- srcValid_in  in  1  source valid.
- srcReady_out  out  1  source ready.
- txAddr_out  out  32  qword address of current TLP.
- txLen_out  out  6  qword count: SLOT_QWORDS or 1.
- txData_out  out  64  payload qword.
- txSop_out  out  1  first qword of TLP.
- txEop_out  out  1  last qword of TLP.
- txValid_out  out  1  payload valid.
- txReady_in  in  1  transceiver accepts qword.
- wrPtr_out  out  PTR_W  current write pointer.
- full_out  out  1  ring full.
- busy_out  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; wrPtr = rdPtr = 0; FIFO empty; FSM = IDLE.
- Qword handshake: transfer when txValid_out && txReady_in. tx* outputs are held stable while txValid_out=1 && !txReady_in. txAddr_out and txLen_out are constant for the whole TLP.
- FIFO:
  - push on srcValid_in && srcReady_out.
  - srcReady_out = dmaEnable_in && FIFO not full; registered-free, i.e. combinational from the registered count.
- full_out = ((wrPtr+1) mod NUM_SLOTS) == rdPtr; one slot is always kept free.
- rdPtr: on rdPtrWrite_in, rdPtr <= rdPtrData_in. Takes effect in any state. A strobe coinciding with a wrPtr increment applies both; full_out reflects both next cycle.
- FSM states:
  - IDLE:
    - dmaEnable_in=0 -> wrPtr <= 0, rdPtr <= 0 (an rdPtr strobe in the same cycle is ignored), FIFO flushed.
    - else if FIFO count >= SLOT_QWORDS && !full_out -> DATA. Latch txAddr = cfgF2CBase_in + wrPtr*SLOT_QWORDS, txLen = SLOT_QWORDS.
  - DATA:
    - txValid_out=1; data popped from FIFO per transfer.
    - Sop on qword 0; Eop on qword SLOT_QWORDS-1.
    - On final transfer: wrPtr <= wrPtr+1 (wraps), -> MTR.
  - MTR:
    - Single qword: txAddr = cfgMtrBase_in, txLen = 1, data = zero-extended new wrPtr, Sop=Eop=1.
    - On transfer -> IDLE.
- Earliest data TLP start: 1 cycle after the FIFO reaches SLOT_QWORDS. No idle cycles between DATA and MTR when txReady_in=1.
- dmaEnable_in falling mid-DATA or mid-MTR: the current TLP and its metrics write complete; the flush happens in IDLE. A TLP is never truncated.
- Config bases are sampled only at TLP start; changes mid-TLP do not affect the TLP in flight.
- Address arithmetic is modulo 2^32.
- Async reset mid-TLP aborts immediately; all outputs go to 0.

Optional Feature:
- Macro F2C_DMA_SCHED_STATS_EN.
- Defined: adds output port stallCount_out, 32 bits. It increments each cycle FSM=IDLE && FIFO count >= SLOT_QWORDS && full_out. It saturates at 0xFFFFFFFF and clears when dmaEnable_in=0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Basic slot write:
  - Stimulus: F2CBase=0, MtrBase=0x100, enable, stream 16 qwords SEQ64[0..15], txReady=1.
  - Response: TLP addr 0x0, len 16, Sop on qword 0, Eop on qword 15, data SEQ64[0..15]; then TLP addr 0x100, len 1, data 0x1; wrPtr_out=1.
- Full ring:
  - Stimulus: stream 16*16 qwords, no rdPtr writes.
  - Response: 15 data TLPs at addrs 0x0,0x10..0xE0; full_out=1 with wrPtr=15; the 16th TLP is withheld.
  - Then write rdPtr=1: 16th TLP goes to addr 0xF0, wrPtr wraps to 0, metrics data 0x0.
- Backpressure:
  - Stimulus: txReady toggles 1/0 every cycle during DATA.
  - Response: 16 qwords delivered in order; outputs stable during stalls; Sop/Eop exactly once each.
- Disable mid-TLP:
  - Stimulus: drop dmaEnable after qword 5 of slot 0.
  - Response: all 16 qwords and metrics write (data 0x1) complete; then wrPtr=0, FIFO empty, srcReady=0.
- Simultaneous rdPtr write and wrPtr increment:
  - Setup: wrPtr=14, rdPtr=0.
  - Stimulus: last qword of slot 14 accepted in the same cycle as an rdPtr=3 strobe.
  - Response: wrPtr=15, rdPtr=3, full_out=0 next cycle.
- Stats (F2C_DMA_SCHED_STATS_EN):
  - Stimulus: ring full with FIFO holding 16 qwords for 100 cycles.
  - Response: stallCount_out=100; it clears to 0 when dmaEnable_in=0.
